key_pression: RTL and testbench

- Converts the two raw push-button inputs into the four single-cycle press events consumed by the clock controller: short_pression1/0 and long_pression1/0.
- Per key: 2-FF synchronizer, counter debounce, then a hold-time FSM that classifies each press as short or long.
- Sits between the board key pins and the clock top level; one instance serves both keys.

---
 rtl/key_pression_pkg.sv | 13 +
 rtl/key_filter.sv | 100 ++++++++++
 rtl/key_pression.sv | 44 ++++
 tb/tb_key_pression.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/key_pression_pkg.sv
// Shared defaults and hold-FSM state encoding for the key press classifier.
package key_pression_pkg;

  localparam int KEY_DEBOUNCE_CYC = 1_000_000;  // 20 ms at 50 MHz
  localparam int KEY_LONG_CYC     = 50_000_000; // 1 s at 50 MHz

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_WAIT = 2'd2
  } hold_state_e;

endpackage

// File: rtl/key_filter.sv
// One key: 2-FF synchronizer, counter debounce and a hold-time FSM that emits
// exactly one registered short or long pulse per debounced press.
module key_filter
  import key_pression_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = KEY_DEBOUNCE_CYC,
  parameter int LONG_CYC       = KEY_LONG_CYC,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic sysclk,
  input  logic rst,
  input  logic key_raw,
  output logic short_p,
  output logic long_p
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HOLD_W = $clog2(LONG_CYC) + 1;

  logic              pressed_raw;
  logic              sync1_q, sync2_q;
  logic              deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  hold_state_e       state_q, state_d;
  logic              short_q, short_d;
  logic              long_q, long_d;

  // Normalise polarity before synchronizing so reset can load "released" as 0.
  assign pressed_raw = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (deb_q) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!deb_q) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
          long_d  = 1'b1;
          state_d = LONG_WAIT;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LONG_WAIT: begin
        // Release after a long press is silent.
        if (!deb_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      state_q <= IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign short_p = short_q;
  assign long_p  = long_q;

endmodule

// File: rtl/key_pression.sv
// Two independent key filters turning raw board keys into single-cycle
// short/long press events for the clock controller.
module key_pression
  import key_pression_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = KEY_DEBOUNCE_CYC,
  parameter int LONG_CYC       = KEY_LONG_CYC,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic sysclk,
  input  logic rst,
  input  logic key1,
  input  logic key0,
  output logic short_pression1,
  output logic long_pression1,
  output logic short_pression0,
  output logic long_pression0
);

  key_filter #(
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .LONG_CYC      (LONG_CYC),
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_key1 (
    .sysclk (sysclk),
    .rst    (rst),
    .key_raw(key1),
    .short_p(short_pression1),
    .long_p (long_pression1)
  );

  key_filter #(
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .LONG_CYC      (LONG_CYC),
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_key0 (
    .sysclk (sysclk),
    .rst    (rst),
    .key_raw(key0),
    .short_p(short_pression0),
    .long_p (long_pression0)
  );

endmodule

// File: tb/tb_key_pression.sv
// Directed bench for key_pression with DEBOUNCE_CYC=4, LONG_CYC=20, active-low keys.
module tb_key_pression;

  logic sysclk = 1'b0;
  logic rst, key1, key0;
  logic short_pression1, long_pression1, short_pression0, long_pression0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_s1, n_l1, n_s0, n_l0;
  int at_s1, at_l1, at_s0, at_l0;
  int rst_out_seen;
  int deb0_seen;

  always #5 sysclk = ~sysclk;

  key_pression #(
    .DEBOUNCE_CYC  (4),
    .LONG_CYC      (20),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .sysclk         (sysclk),
    .rst            (rst),
    .key1           (key1),
    .key0           (key0),
    .short_pression1(short_pression1),
    .long_pression1 (long_pression1),
    .short_pression0(short_pression0),
    .long_pression0 (long_pression0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_s1 = 0; n_l1 = 0; n_s0 = 0; n_l0 = 0;
    at_s1 = -1; at_l1 = -1; at_s0 = -1; at_l0 = -1;
    rst_out_seen = 0;
    deb0_seen = 0;
  endtask

  // One clock edge; cyc is the index of the edge just taken.
  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
    if (short_pression1) begin n_s1++; at_s1 = cyc; end
    if (long_pression1)  begin n_l1++; at_l1 = cyc; end
    if (short_pression0) begin n_s0++; at_s0 = cyc; end
    if (long_pression0)  begin n_l0++; at_l0 = cyc; end
    if (rst && (short_pression1 || long_pression1 || short_pression0 || long_pression0))
      rst_out_seen = 1;
    if (dut.u_key0.deb_q) deb0_seen = 1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // A raw change driven after edge t is sampled at edge t+1; deb follows at t+6.
  // A press applied after edge t0 enters PRESSED at t0+7 and, if held, the long
  // pulse is high after edge t0+27. A release after edge t1 gives a short pulse
  // high after edge t1+7.
  initial begin
    clr();
    rst  = 1'b1;
    key1 = 1'b0;
    key0 = 1'b0;

    // Reset with both keys pressed.
    tick(); tick(); tick();
    chk("rst_outputs_quiet", rst_out_seen, 0);
    chk("rst_deb1_clear", int'(dut.u_key1.deb_q), 0);
    rst = 1'b0;                               // cyc 3
    run_to(8);
    chk("deb1_before_latency", int'(dut.u_key1.deb_q), 0);
    run_to(9);
    chk("deb1_after_latency", int'(dut.u_key1.deb_q), 1);
    chk("deb0_after_latency", int'(dut.u_key0.deb_q), 1);

    // Simultaneous release of the presses held through reset: both short at 16.
    clr();
    key1 = 1'b1;
    key0 = 1'b1;
    run_to(20);
    chk("simul_short1_count", n_s1, 1);
    chk("simul_short1_cycle", at_s1, 16);
    chk("simul_short0_count", n_s0, 1);
    chk("simul_short0_cycle", at_s0, 16);
    chk("simul_long_count", n_l1 + n_l0, 0);

    // Short press on key0: press after 20, release after 30.
    clr();
    key0 = 1'b0;
    run_to(30);
    key0 = 1'b1;
    run_to(50);
    chk("short0_count", n_s0, 1);
    chk("short0_cycle", at_s0, 37);
    chk("short0_no_long", n_l0, 0);
    chk("short0_key1_quiet", n_s1 + n_l1, 0);

    // Long press on key1: press after 50 for 40 cycles.
    clr();
    key1 = 1'b0;
    run_to(90);
    key1 = 1'b1;
    run_to(120);
    chk("long1_count", n_l1, 1);
    chk("long1_cycle", at_l1, 77);
    chk("long1_no_short_on_release", n_s1, 0);
    chk("long1_key0_quiet", n_s0 + n_l0, 0);

    // Bounce on key0: 2-cycle pulses never satisfy the 4-cycle debounce.
    clr();
    for (int i = 0; i < 3; i++) begin
      key0 = 1'b0;
      run_to(cyc + 2);
      key0 = 1'b1;
      run_to(cyc + 2);
    end
    run_to(152);
    chk("bounce_deb0_stable", deb0_seen, 0);
    chk("bounce_outputs_quiet", n_s0 + n_l0 + n_s1 + n_l1, 0);

    // Reset mid-press: key1 pressed after 152, hold reaches 15 at 174.
    clr();
    key1 = 1'b0;
    run_to(174);
    rst = 1'b1;
    run_to(176);
    chk("midrst_deb1_clear", int'(dut.u_key1.deb_q), 0);
    chk("midrst_outputs_quiet", rst_out_seen, 0);
    rst = 1'b0;                               // fresh press from 176
    run_to(215);
    chk("midrst_long1_count", n_l1, 1);
    chk("midrst_long1_cycle", at_l1, 203);
    chk("midrst_no_short1", n_s1, 0);
    key1 = 1'b1;
    run_to(230);
    chk("midrst_release_quiet", n_s1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
